// File: rtl/stopwatch_controller_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stopwatch_pkg: shared state encodings and prescaler divide helper | Rev 1.0
// ---------------------------------------------------------------------------
package stopwatch_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUNNING = 3'd1,
    S_LAP     = 3'd2,
    S_PAUSED  = 3'd3,
    S_EXPIRED = 3'd4
  } sw_state_t;

  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_controller_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stopwatch_controller_if: button/datapath signals of the stopwatch controller | Rev 1.0
// ---------------------------------------------------------------------------
interface stopwatch_controller_if;
  logic       start_stop;
  logic       lap_reset;
  logic       mode;
  logic       at_limit;
  logic       count_tick;
  logic       count_up;
  logic       count_clear;
  logic       count_load;
  logic       display_hold;
  logic       alarm;
  logic [2:0] state;

  modport master (
    output start_stop, lap_reset, mode, at_limit,
    input  count_tick, count_up, count_clear, count_load, display_hold, alarm, state
  );

  modport slave (
    input  start_stop, lap_reset, mode, at_limit,
    output count_tick, count_up, count_clear, count_load, display_hold, alarm, state
  );
endinterface
`default_nettype wire

// File: rtl/stopwatch_controller_tick_prescaler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tick_prescaler: 0..DIV-1 wrapping counter with hold, clear and terminal count | Rev 1.0
// ---------------------------------------------------------------------------
module tick_prescaler #(
  parameter int unsigned DIV = 10
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_en,
  input  wire logic i_clr,
  output logic      o_tc
);
  localparam int unsigned c_W = $clog2(DIV);
  localparam logic [c_W-1:0] c_LAST = c_W'(DIV - 1);

  logic [c_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + c_W'(1);
    end
  end

  assign o_tc = (r_cnt == c_LAST);
endmodule
`default_nettype wire

// File: rtl/stopwatch_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stopwatch_controller: button-driven control FSM for the stopwatch counter | Rev 1.0
// ---------------------------------------------------------------------------
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  stopwatch_controller_if.slave sw
);
  localparam int unsigned c_DIV = calc_div(CLK_HZ, TICK_HZ);

  sw_state_t r_state, w_state_nxt;
  logic      r_ss_q, r_lr_q, r_md_q;
  logic      w_ss_edge, w_lr_raw, w_lr_edge, w_md_edge;
  logic      r_count_up, w_count_up_nxt;
  logic      r_tick, r_clear, r_load, r_hold, r_alarm;
  logic      w_tick_nxt, w_clear_nxt, w_load_nxt;
  logic      w_pre_en, w_pre_clr, w_pre_tc;

  assign w_ss_edge = sw.start_stop & ~r_ss_q;
  assign w_lr_raw  = sw.lap_reset  & ~r_lr_q;
  assign w_lr_edge = w_lr_raw & ~w_ss_edge;
  assign w_md_edge = sw.mode & ~r_md_q & ~w_ss_edge & ~w_lr_raw;

  tick_prescaler #(.DIV(c_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_pre_en),
    .i_clr (w_pre_clr),
    .o_tc  (w_pre_tc)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_count_up_nxt = r_count_up;
    w_tick_nxt     = 1'b0;
    w_clear_nxt    = 1'b0;
    w_load_nxt     = 1'b0;
    w_pre_en       = 1'b0;
    w_pre_clr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pre_clr = 1'b1;
        if (w_ss_edge) begin
          w_state_nxt = S_RUNNING;
        end else if (w_lr_edge) begin
          w_clear_nxt = r_count_up;
          w_load_nxt  = ~r_count_up;
        end else if (w_md_edge) begin
          w_count_up_nxt = ~r_count_up;
        end
      end
      S_RUNNING, S_LAP: begin
        // A stop request landing on the tick boundary freezes the prescaler at DIV-1
        w_pre_en = ~(w_ss_edge & w_pre_tc);
        if (w_ss_edge) begin
          w_state_nxt = S_PAUSED;
        end else if (w_pre_tc && sw.at_limit) begin
          w_state_nxt = S_EXPIRED;
        end else begin
          w_tick_nxt = w_pre_tc;
          if (w_lr_edge) begin
            w_state_nxt = (r_state == S_RUNNING) ? S_LAP : S_RUNNING;
          end
        end
      end
      S_PAUSED: begin
        if (w_ss_edge) begin
          w_state_nxt = S_RUNNING;
        end else if (w_lr_edge) begin
          w_state_nxt = S_IDLE;
          w_clear_nxt = r_count_up;
          w_load_nxt  = ~r_count_up;
        end
      end
      S_EXPIRED: begin
        w_pre_clr = 1'b1;
        if (w_lr_raw) begin
          w_state_nxt = S_IDLE;
          w_clear_nxt = r_count_up;
          w_load_nxt  = ~r_count_up;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pre_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_count_up <= 1'b1;
      r_tick     <= 1'b0;
      r_clear    <= 1'b0;
      r_load     <= 1'b0;
      r_hold     <= 1'b0;
      r_alarm    <= 1'b0;
      r_ss_q     <= 1'b0;
      r_lr_q     <= 1'b0;
      r_md_q     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count_up <= w_count_up_nxt;
      r_tick     <= w_tick_nxt;
      r_clear    <= w_clear_nxt;
      r_load     <= w_load_nxt;
      r_hold     <= (w_state_nxt == S_LAP);
      r_alarm    <= (w_state_nxt == S_EXPIRED);
      r_ss_q     <= sw.start_stop;
      r_lr_q     <= sw.lap_reset;
      r_md_q     <= sw.mode;
    end
  end

  assign sw.state        = r_state;
  assign sw.count_up     = r_count_up;
  assign sw.count_tick   = r_tick;
  assign sw.count_clear  = r_clear;
  assign sw.count_load   = r_load;
  assign sw.display_hold = r_hold;
  assign sw.alarm        = r_alarm;
endmodule
`default_nettype wire

// File: tb/tb_stopwatch_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_stopwatch_controller: directed scenarios plus random buttons vs. a reference model | Rev 1.0
// ---------------------------------------------------------------------------
module tb_stopwatch_controller;
  localparam int DIV = 10;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_LAP = 2, ST_PAUSE = 3, ST_EXP = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  stopwatch_controller_if sw();

  stopwatch_controller #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw)
  );

  always #5 clk = ~clk;

  // reference model state
  int m_state = ST_IDLE;
  int m_pre   = 0;
  bit m_up = 1'b1, m_tick = 1'b0, m_clr = 1'b0, m_load = 1'b0;
  bit h_ss = 1'b0, h_lr = 1'b0, h_md = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit e_ss, e_lr, e_md, running, bnd;
    if (!rst_n) begin
      m_state = ST_IDLE; m_pre = 0; m_up = 1'b1;
      m_tick = 1'b0; m_clr = 1'b0; m_load = 1'b0;
      h_ss = 1'b0; h_lr = 1'b0; h_md = 1'b0;
      return;
    end
    e_ss = sw.start_stop && !h_ss;
    e_lr = sw.lap_reset  && !h_lr;
    e_md = sw.mode       && !h_md;
    m_tick = 1'b0; m_clr = 1'b0; m_load = 1'b0;
    running = (m_state == ST_RUN) || (m_state == ST_LAP);
    bnd = running && (m_pre == DIV - 1);
    if (running) begin
      if (!(bnd && e_ss)) m_pre = (m_pre + 1) % DIV;
    end else if (m_state != ST_PAUSE) begin
      m_pre = 0;
    end
    case (m_state)
      ST_IDLE: begin
        if (e_ss) m_state = ST_RUN;
        else if (e_lr) begin m_clr = m_up; m_load = !m_up; end
        else if (e_md) m_up = !m_up;
      end
      ST_RUN, ST_LAP: begin
        if (e_ss) m_state = ST_PAUSE;
        else if (bnd && sw.at_limit) m_state = ST_EXP;
        else begin
          m_tick = bnd;
          if (e_lr) m_state = (m_state == ST_RUN) ? ST_LAP : ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (e_ss) m_state = ST_RUN;
        else if (e_lr) begin m_state = ST_IDLE; m_clr = m_up; m_load = !m_up; end
      end
      default: begin
        if (e_lr) begin m_state = ST_IDLE; m_clr = m_up; m_load = !m_up; end
      end
    endcase
    h_ss = sw.start_stop; h_lr = sw.lap_reset; h_md = sw.mode;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_eq("state",        sw.state,        m_state);
    check_eq("count_up",     sw.count_up,     m_up);
    check_eq("count_tick",   sw.count_tick,   m_tick);
    check_eq("count_clear",  sw.count_clear,  m_clr);
    check_eq("count_load",   sw.count_load,   m_load);
    check_eq("display_hold", sw.display_hold, (m_state == ST_LAP));
    check_eq("alarm",        sw.alarm,        (m_state == ST_EXP));
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    int tk[$];
    int ticks, first, hold_n, exp_at;
    sw.start_stop = 1'b0; sw.lap_reset = 1'b0; sw.mode = 1'b0; sw.at_limit = 1'b0;
    rst_n = 1'b0;
    run(2);
    check_eq("rst_state", sw.state, ST_IDLE);
    check_eq("rst_up", sw.count_up, 1);
    rst_n = 1'b1;

    // 1: ticks at 10/20/30 cycles after entering RUNNING
    sw.start_stop = 1'b1; cyc();
    check_eq("p1_enter", sw.state, ST_RUN);
    sw.start_stop = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      cyc();
      if (sw.count_tick) tk.push_back(k);
    end
    check_eq("p1_nticks", tk.size(), 3);
    if (tk.size() == 3) foreach (tk[i]) check_eq("p1_tick_at", tk[i], 10 * (i + 1));
    sw.start_stop = 1'b1; cyc(); sw.start_stop = 1'b0;
    sw.lap_reset = 1'b1; cyc();
    check_eq("p1_idle", sw.state, ST_IDLE);
    check_eq("p1_clear", sw.count_clear, 1);
    sw.lap_reset = 1'b0; cyc();

    // 2: pause keeps the sub-tick fraction
    sw.start_stop = 1'b1; cyc(); sw.start_stop = 1'b0;
    ticks = 0;
    for (int k = 1; k <= 14; k++) begin cyc(); ticks += sw.count_tick; end
    sw.start_stop = 1'b1; cyc(); sw.start_stop = 1'b0;
    check_eq("p2_paused", sw.state, ST_PAUSE);
    check_eq("p2_ticks_run", ticks, 1);
    ticks = 0;
    for (int k = 0; k < 12; k++) begin cyc(); ticks += sw.count_tick; end
    check_eq("p2_ticks_paused", ticks, 0);
    sw.start_stop = 1'b1; cyc(); sw.start_stop = 1'b0;
    first = 0;
    for (int j = 1; j <= 20; j++) begin
      cyc();
      if (sw.count_tick && first == 0) first = j;
    end
    check_eq("p2_resume_tick", first, 5);

    // 3: lap freeze span, ticks continue
    sw.lap_reset = 1'b1; cyc(); sw.lap_reset = 1'b0;
    hold_n = sw.display_hold; ticks = sw.count_tick;
    for (int k = 0; k < 19; k++) begin cyc(); hold_n += sw.display_hold; ticks += sw.count_tick; end
    sw.lap_reset = 1'b1; cyc(); sw.lap_reset = 1'b0;
    check_eq("p3_hold_span", hold_n, 20);
    check_eq("p3_lap_ticks", ticks, 2);
    check_eq("p3_hold_off", sw.display_hold, 0);
    check_eq("p3_back_run", sw.state, ST_RUN);

    // 4: down mode, preset load, expiry
    sw.start_stop = 1'b1; cyc(); sw.start_stop = 1'b0;
    sw.lap_reset = 1'b1; cyc(); sw.lap_reset = 1'b0; cyc();
    sw.mode = 1'b1; cyc(); sw.mode = 1'b0;
    check_eq("p4_down", sw.count_up, 0);
    sw.lap_reset = 1'b1; cyc(); sw.lap_reset = 1'b0;
    check_eq("p4_load", sw.count_load, 1);
    check_eq("p4_noclear", sw.count_clear, 0);
    sw.at_limit = 1'b1;
    sw.start_stop = 1'b1; cyc(); sw.start_stop = 1'b0;
    exp_at = 0; ticks = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      ticks += sw.count_tick;
      if (sw.state == ST_EXP && exp_at == 0) exp_at = k;
    end
    check_eq("p4_expire_at", exp_at, 10);
    check_eq("p4_no_tick", ticks, 0);
    check_eq("p4_alarm", sw.alarm, 1);
    sw.start_stop = 1'b1; cyc(); sw.start_stop = 1'b0;
    check_eq("p4_ss_ignored", sw.state, ST_EXP);
    cyc();
    sw.lap_reset = 1'b1; cyc(); sw.lap_reset = 1'b0;
    check_eq("p4_idle", sw.state, ST_IDLE);
    check_eq("p4_load2", sw.count_load, 1);
    check_eq("p4_alarm_off", sw.alarm, 0);
    sw.at_limit = 1'b0;
    sw.mode = 1'b1; cyc(); sw.mode = 1'b0;
    check_eq("p4_up_again", sw.count_up, 1);

    // 5: priority, held buttons, mode ignored outside IDLE
    sw.start_stop = 1'b1; cyc(); sw.start_stop = 1'b0; cyc();
    sw.start_stop = 1'b1; sw.lap_reset = 1'b1; cyc();
    check_eq("p5_pause", sw.state, ST_PAUSE);
    check_eq("p5_nohold", sw.display_hold, 0);
    run(5);
    check_eq("p5_held", sw.state, ST_PAUSE);
    sw.start_stop = 1'b0; sw.lap_reset = 1'b0; cyc();
    sw.start_stop = 1'b1; cyc(); sw.start_stop = 1'b0;
    sw.mode = 1'b1; cyc(); sw.mode = 1'b0;
    check_eq("p5_mode_ign", sw.count_up, 1);
    check_eq("p5_running", sw.state, ST_RUN);
    cyc();

    // 6: reset while in LAP
    sw.lap_reset = 1'b1; cyc(); sw.lap_reset = 1'b0;
    check_eq("p6_lap", sw.state, ST_LAP);
    run(3);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    check_eq("p6_state", sw.state, ST_IDLE);
    check_eq("p6_hold", sw.display_hold, 0);
    check_eq("p6_up", sw.count_up, 1);

    // random button activity
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) sw.start_stop = ~sw.start_stop;
      if ($urandom_range(0, 19) == 0) sw.lap_reset  = ~sw.lap_reset;
      if ($urandom_range(0, 14) == 0) sw.mode       = ~sw.mode;
      sw.at_limit = ($urandom_range(0, 29) == 0);
      rst_n = ($urandom_range(0, 399) != 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/stopwatch_controller.md
Name: stopwatch_controller

Overview:
Control FSM that sequences the stopwatch counter datapath from three debounced button levels. It sits between the debouncers and the digit counter/display chain in au_top.
- Generates the counter's tick, direction, clear and preset-load strobes.
- Holds a display freeze for lap capture.
- Stops the count at its limit, with no wrap, and raises an alarm.

Parameters:
CLK_HZ, 100_000_000, board clock frequency in Hz
TICK_HZ, 100, count rate in Hz; DIV = CLK_HZ/TICK_HZ; CLK_HZ must be an exact multiple of TICK_HZ and DIV >= 2

Ports:
clk  in  1  board clock
rst_n  in  1  reset, synchronous, active-low
start_stop  in  1  debounced level; rising edge = start/stop request
lap_reset  in  1  debounced level; rising edge = lap/reset request
mode  in  1  debounced level; rising edge toggles count direction (IDLE only)
at_limit  in  1  from datapath: count == 0 in down mode, count == max in up mode
count_tick  out  1  1-cycle pulse; counter steps by one
count_up  out  1  direction to counter: 1 = up, 0 = down
count_clear  out  1  1-cycle pulse; counter to 0 (up mode)
count_load  out  1  1-cycle pulse; counter loads preset (down mode)
display_hold  out  1  display shows frozen lap value while 1
alarm  out  1  high while EXPIRED
state  out  3  current FSM state encoding, for LEDs/debug

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - state = IDLE; count_up = 1.
  - count_tick, count_clear, count_load, display_hold, alarm = 0.
  - Prescaler = 0; edge-detect history regs = 0.
  - Reset mid-count abandons the run. No clear/load pulse is issued; the datapath has its own reset.
- Edge detection: edge = input high AND history register low. History updates every cycle. An input held high produces exactly one edge.
- All outputs are registered. An edge detected in cycle N changes the state and outputs at the edge ending cycle N (visible in cycle N+1).
- Edge priority in one cycle: start_stop > lap_reset > mode. Lower-priority edges in that cycle are discarded, not queued.
- States: IDLE, RUNNING, LAP, PAUSED, EXPIRED.
- IDLE:
  - start_stop -> RUNNING.
  - lap_reset -> stay; pulse count_clear if count_up = 1, else count_load.
  - mode -> toggle count_up.
- RUNNING:
  - start_stop -> PAUSED.
  - lap_reset -> LAP; display_hold = 1.
- LAP:
  - start_stop -> PAUSED; display_hold = 0.
  - lap_reset -> RUNNING; display_hold = 0.
- PAUSED:
  - start_stop -> RUNNING.
  - lap_reset -> IDLE plus clear/load pulse, selected by count_up.
- EXPIRED:
  - alarm = 1; start_stop ignored.
  - lap_reset -> IDLE plus clear/load pulse; alarm = 0.
- mode edges outside IDLE are ignored. count_up changes only in IDLE.
- Prescaler:
  - Counts 0..DIV-1 only in RUNNING/LAP and wraps to 0.
  - Holds its value in PAUSED, so a paused run keeps its sub-tick fraction.
  - Cleared to 0 in IDLE and EXPIRED.
- Tick: when the prescaler is at DIV-1 in RUNNING/LAP:
  - at_limit = 0 -> count_tick = 1 next cycle.
  - at_limit = 1 -> no tick; go to EXPIRED; display_hold = 0.
- Starting with at_limit already 1 (e.g. down mode with preset 0) expires at the first tick boundary, after DIV cycles.
- Tick boundary coinciding with a start_stop edge: the button wins. No tick is issued and the prescaler holds.
- count_clear, count_load and count_tick are never asserted in the same cycle.

Decomposition:
- Shared package stopwatch_pkg:
  - state encodings: IDLE = 0, RUNNING = 1, LAP = 2, PAUSED = 3, EXPIRED = 4.
  - DIV computation function.
- Sub-module tick_prescaler (enable, clear, DIV parameter, terminal-count output), instantiated once.
- Edge detection stays inline.

Test Plan:
All scenarios use CLK_HZ = 1000, TICK_HZ = 100, so DIV = 10.
1. Reset, then a start_stop edge, then run 35 cycles -> RUNNING; count_tick pulses at 10, 20 and 30 cycles after entry; count_up = 1; no clear/load pulses.
2. Start; stop after 15 cycles; start again -> PAUSED with prescaler at 5 and no ticks while paused; after restart the next tick comes 5 cycles later.
3. While RUNNING, lap_reset edge, 20 cycles, lap_reset edge -> display_hold 1 for exactly that span; ticks continue throughout.
4. IDLE: mode edge, then lap_reset -> count_up = 0, one count_load pulse. Start with at_limit = 1 -> EXPIRED after 10 cycles with alarm = 1 and no tick. start_stop ignored. lap_reset -> IDLE, count_load pulse, alarm = 0.
5. start_stop and lap_reset edges in the same cycle while RUNNING -> PAUSED, display_hold stays 0. A held-high button gives one action only. mode edge while RUNNING leaves count_up unchanged.
6. rst_n low for one cycle while in LAP -> next cycle state = IDLE; display_hold, alarm and all strobes = 0; count_up = 1.
